// File: rtl/program_loader_pkg.sv
// Shared types and constants for the MC14500B serial program loader.
// PROGRAM_LOADER_PARITY_EN selects an 8E1 frame with an extra RX_PARITY state.
package loader_pkg;

  localparam int BYTES_PER_WORD = 2;

`ifdef PROGRAM_LOADER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef PROGRAM_LOADER_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    WAIT_LO,
    WAIT_HI,
    WRITE
  } word_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Program-RAM write port: the loader drives it as master, the RAM consumes it as slave.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 12
);

  logic                  program_write;
  logic [DATA_WIDTH-1:0] program_cmd;
  logic [ADDR_WIDTH-1:0] program_address;

  modport master (output program_write, output program_cmd, output program_address);
  modport slave  (input  program_write, input  program_cmd, input  program_address);

endinterface

// File: rtl/program_loader_uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and byte/error pulses.
// PROGRAM_LOADER_PARITY_EN adds an even-parity bit check before the stop bit.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       err_pulse
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(7);
`ifdef PROGRAM_LOADER_PARITY_EN
  localparam rx_state_t AFTER_DATA = RX_PARITY;
`else
  localparam rx_state_t AFTER_DATA = RX_STOP;
`endif

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t     state_q;
  logic [BW-1:0] baud_q;
  logic [CW-1:0] bit_q;
  logic [7:0]    shift_q;
  logic          valid_q, err_q;
  logic          stop_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

`ifdef PROGRAM_LOADER_PARITY_EN
  logic par_err_q;
  assign stop_ok = rx_sync_q & ~par_err_q;
`else
  assign stop_ok = rx_sync_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RX_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef PROGRAM_LOADER_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= RX_START;
            baud_q  <= '0;
          end
        end
        // A start bit that is high again at mid-bit is treated as a glitch.
        RX_START: begin
          if (baud_q == HALF_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_q == FULL_LAST) begin
            baud_q  <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            state_q <= (bit_q == LAST_BIT) ? AFTER_DATA : RX_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef PROGRAM_LOADER_PARITY_EN
        RX_PARITY: begin
          if (baud_q == FULL_LAST) begin
            baud_q    <= '0;
            par_err_q <= rx_sync_q ^ (^shift_q);
            state_q   <= RX_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        // Returning to idle right at the sample point keeps back-to-back frames aligned.
        RX_STOP: begin
          if (baud_q == FULL_LAST) begin
            baud_q  <= '0;
            state_q <= RX_IDLE;
            if (stop_ok) begin
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign err_pulse  = err_q;

endmodule

// File: rtl/program_loader.sv
// MC14500B program loader: pairs UART bytes into instruction words and writes them to program RAM.
// Define PROGRAM_LOADER_PARITY_EN to receive 8E1 frames instead of 8N1.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter int CLKS_PER_BIT      = 16,
  parameter int IDLE_TIMEOUT      = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  program_loader_if.master  prog,
  output logic              loading,
  output logic              frame_error
);

  localparam int HI_BITS = DATA_WIDTH - 8 * (BYTES_PER_WORD - 1);
  localparam int TW      = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] IDLE_MAX  = TW'(IDLE_TIMEOUT);

  logic                  byte_valid, err_pulse;
  logic [7:0]            byte_data;
  word_state_t           word_state_q;
  logic [7:0]            lo_byte_q;
  logic [ADDR_WIDTH-1:0] addr_q, wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_cmd_q;
  logic                  wr_q, loading_q, frame_error_q;
  logic [TW-1:0]         idle_cnt_q;
  logic                  idle_expire;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .err_pulse  (err_pulse)
  );

  // Fires once, on the cycle the idle count reaches IDLE_TIMEOUT; the count then saturates.
  assign idle_expire = !byte_valid && (idle_cnt_q == IDLE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q    <= '0;
      frame_error_q <= 1'b0;
    end else begin
      if (byte_valid) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != IDLE_MAX) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
      if (err_pulse) begin
        frame_error_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_state_q <= WAIT_LO;
      lo_byte_q    <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      wr_cmd_q     <= '0;
      wr_q         <= 1'b0;
      loading_q    <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (word_state_q)
        WAIT_LO: begin
          if (byte_valid) begin
            lo_byte_q    <= byte_data;
            loading_q    <= 1'b1;
            word_state_q <= WAIT_HI;
          end else if (idle_expire && loading_q) begin
            loading_q <= 1'b0;
            addr_q    <= '0;
          end
        end
        WAIT_HI: begin
          if (byte_valid) begin
            wr_cmd_q     <= {byte_data[HI_BITS-1:0], lo_byte_q};
            wr_addr_q    <= addr_q;
            wr_q         <= 1'b1;
            word_state_q <= WRITE;
          end else if (idle_expire) begin
            word_state_q <= WAIT_LO;
          end
        end
        WRITE: begin
          addr_q       <= addr_q + 1'b1;
          word_state_q <= WAIT_LO;
        end
        default: word_state_q <= WAIT_LO;
      endcase
    end
  end

  assign prog.program_write   = wr_q;
  assign prog.program_cmd     = wr_cmd_q;
  assign prog.program_address = wr_addr_q;
  assign loading              = loading_q;
  assign frame_error          = frame_error_q;

endmodule

// File: doc/program_loader.md
# program_loader

Serial program loader for the MC14500B core. It receives an 8N1 UART byte stream and assembles consecutive byte pairs into `DATA_WIDTH`-bit instruction words. It writes them into the program RAM through the `program_write` / `program_cmd` / address port at sequential addresses. It is the write-side counterpart of the program-RAM write interface and holds the CPU while a load session is in progress.

## Interface
- `ADDR_WIDTH`, 8, program RAM address width
- `INSTRUCTION_WIDTH`, 4, opcode width
- `DATA_WIDTH`, `ADDR_WIDTH + INSTRUCTION_WIDTH`, word width; must be ≤ 16
- `CLKS_PER_BIT`, 16, clk cycles per UART bit; must be ≥ 4
- `IDLE_TIMEOUT`, 4096, idle clk cycles that end a partial word or a session
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `rx`  in  1  UART line, idle high, asynchronous to `clk`
- `program_write`  out  1  one-cycle write strobe
- `program_cmd`  out  DATA_WIDTH  word to write
- `program_address`  out  ADDR_WIDTH  target address
- `loading`  out  1  load session active; drives CPU hold/reset
- `frame_error`  out  1  sticky framing or parity error flag

## Operation
- **Reset values:** all outputs are 0; address counter is 0; both FSMs are idle.
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, reset to 1.
- **RX FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - IDLE → START on a synchronized falling edge.
  - START: wait `CLKS_PER_BIT/2`. If `rx` is still low → DATA; otherwise treat as a glitch → IDLE.
  - DATA: sample 8 bits LSB first, each `CLKS_PER_BIT` after the previous sample point.
  - STOP: sample the stop bit. If high, pulse `byte_valid` for 1 cycle. If low, set `frame_error` and drop the byte. Then → IDLE.
- **Word FSM states:** WAIT_LO, WAIT_HI, WRITE.
  - WAIT_LO: a byte is stored as `cmd[7:0]`; `loading` is set to 1 → WAIT_HI.
  - WAIT_HI: a byte supplies `cmd[DATA_WIDTH-1:8]`; its upper unused bits are ignored → WRITE.
  - WRITE: `program_write` is 1 for exactly one cycle, with `program_cmd` and `program_address` valid. Then the address increments modulo 2^ADDR_WIDTH (255 → 0) and the FSM → WAIT_LO.
- **Timeouts:**
  - In WAIT_HI, `IDLE_TIMEOUT` cycles without a byte discard the partial word → WAIT_LO. The address is unchanged and nothing is written.
  - In WAIT_LO with `loading`=1, `IDLE_TIMEOUT` cycles without a byte clear `loading` and reset the address to 0.
- **Timeout counter:** cleared by every `byte_valid`; saturates and does not wrap.
- **Dropped bytes:** a byte dropped on a framing error does not advance the word FSM and does not clear the timeout counter.
- **`frame_error`:** cleared only by reset.
- **Reset mid-operation:** asserting reset during a frame or word aborts immediately. No write occurs and the address returns to 0.

## Timing
- `rx` fall to the START-state edge detect: 2–3 cycles (synchronizer).
- Sample points are `CLKS_PER_BIT/2 + k·CLKS_PER_BIT` after the detected start edge.
- `byte_valid` is asserted the cycle after the stop-bit sample.
- `program_write` is asserted 1 cycle after the high byte's `byte_valid`.
- `program_cmd` and `program_address` are registered and stable from that cycle until the next write.
- Back-to-back frames with no idle bit are accepted. STOP returns to IDLE right after the sample point, so the next start edge is caught.
- `loading` rises the cycle after the first low byte's `byte_valid`. It falls the cycle the idle count reaches `IDLE_TIMEOUT`.

## Configuration
- `PROGRAM_LOADER_PARITY_EN` defined:
  - Frame is 8E1 and the RX FSM includes the PARITY state.
  - A parity mismatch sets `frame_error` and drops the byte, exactly as a bad stop bit does.
- Not defined: frame is 8N1 and no PARITY state exists.

## Structure
- Shared package `loader_pkg`:
  - `rx_state_t` and `word_state_t` enums
  - `BYTES_PER_WORD` = 2
  - frame bit count localparam
- Sub-module `uart_rx`:
  - contains the synchronizer, RX FSM, bit counter, baud counter and optional parity check
  - outputs `byte_valid`, `byte_data[7:0]` and `err_pulse`
- `program_loader` holds the word FSM, address counter, timeout counter and sticky flag.

## Test plan
All scenarios run with `CLKS_PER_BIT`=4 and `IDLE_TIMEOUT`=64.
- **Single word:** send 0x3C then 0x0A → one `program_write` with `program_cmd`=0xA3C, `program_address`=0; `loading`=1, then 0 after 64 idle cycles.
- **Sequence and wrap:** send 257 words back-to-back → addresses 0..255 then 0. The final write is at address 0 with the 257th word.
- **Partial word:** send 0x55, then idle 64 cycles, then 0x11, 0x02 → exactly one write, 0x211 at address 0.
- **Framing error:** send 0x12 with the stop bit low → `frame_error`=1 and no FSM advance. Then 0x34, 0x05 → write of 0x534, and `frame_error` stays 1.
- **Glitch and reset:** a 1-cycle low pulse on `rx` → no byte is received. Assert `reset_n`=0 mid-DATA → all outputs are 0 and the next full word is written at address 0.
- **Parity (with `PROGRAM_LOADER_PARITY_EN`):** 0x01 with parity bit 0 → `frame_error`=1 and the byte is dropped. 0x01 with parity bit 1 → accepted.
